// File: rtl/nabp_map_sequencer_if.sv
// Bus bundle between the map sequencer and its angle ROM, line buffer and mapper.
// The master modport is the sequencer side.
interface nabp_map_sequencer_if #(
  parameter int unsigned ACCU_W  = 24,
  parameter int unsigned ANGLE_W = 8
);
  logic               rom_en;
  logic [ANGLE_W-1:0] rom_addr;
  logic [ACCU_W-1:0]  rom_init;
  logic [ACCU_W-1:0]  rom_base;
  logic               lb_ready;
  logic               stall;
  logic [ACCU_W-1:0]  mp_accu_init;
  logic [ACCU_W-1:0]  mp_accu_base;
  logic               sh_kick;
  logic               sh_shift_en;
  logic               sh_done;

  modport master (
    output rom_en, rom_addr, mp_accu_init, mp_accu_base, sh_kick, sh_shift_en, sh_done,
    input  rom_init, rom_base, lb_ready, stall
  );

  modport slave (
    input  rom_en, rom_addr, mp_accu_init, mp_accu_base, sh_kick, sh_shift_en, sh_done,
    output rom_init, rom_base, lb_ready, stall
  );
endinterface

// File: rtl/nabp_map_sequencer.sv
// Steps the projection-line mapper through every angle of a frame: fetch ROM params,
// wait for the line buffer, then kick / shift LINE_LEN times / done.
module nabp_map_sequencer #(
  parameter int unsigned ACCU_W     = 24,
  parameter int unsigned ANGLE_W    = 8,
  parameter int unsigned NUM_ANGLES = 180,
  parameter int unsigned LINE_LEN   = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  nabp_map_sequencer_if.master map_if,
  output logic [ANGLE_W-1:0]   angle_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);
  localparam int unsigned        CntW      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [CntW-1:0]    CntLast   = CntW'(LINE_LEN - 1);
  localparam logic [ANGLE_W-1:0] AngleLast = ANGLE_W'(NUM_ANGLES - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StArm, StKick, StShift, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ACCU_W-1:0]  init_q, init_d;
  logic [ACCU_W-1:0]  base_q, base_d;
  logic               rom_en, kick, shift_en, done, frame_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      angle_q <= '0;
      cnt_q   <= '0;
      init_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    angle_d    = angle_q;
    cnt_d      = cnt_q;
    init_d     = init_q;
    base_d     = base_q;
    rom_en     = 1'b0;
    kick       = 1'b0;
    shift_en   = 1'b0;
    done       = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        rom_en  = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        init_d  = map_if.rom_init;
        base_d  = map_if.rom_base;
        // ARM collapses into LOAD when the line is already buffered
        state_d = map_if.lb_ready ? StKick : StArm;
      end
      StArm: begin
        if (map_if.lb_ready) state_d = StKick;
      end
      StKick: begin
        kick    = 1'b1;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (!map_if.stall) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CntLast) state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (angle_q == AngleLast) begin
          angle_d    = '0;
          frame_done = 1'b1;
          state_d    = StIdle;
        end else begin
          angle_d = angle_q + 1'b1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything; a cut line still gets a done so the mapper re-arms
    if (abort_i && (state_q != StIdle)) begin
      state_d    = StIdle;
      angle_d    = '0;
      frame_done = 1'b0;
      if (state_q == StShift) begin
        shift_en = 1'b0;
        done     = 1'b1;
      end
    end
  end

  assign map_if.rom_en       = rom_en;
  assign map_if.rom_addr     = angle_q;
  assign map_if.mp_accu_init = init_q;
  assign map_if.mp_accu_base = base_q;
  assign map_if.sh_kick      = kick;
  assign map_if.sh_shift_en  = shift_en;
  assign map_if.sh_done      = done;
  assign angle_o             = angle_q;
  assign busy_o              = (state_q != StIdle);
  assign frame_done_o        = frame_done;
endmodule

// File: tb/tb_nabp_map_sequencer.sv
// Directed bench: dut_a (3 angles x 4 shifts) for a whole frame, dut_b (8 x 8) for
// stall, line-buffer wait, abort and mid-frame reset scenarios.
module tb_nabp_map_sequencer;
  localparam int unsigned AccuW  = 24;
  localparam int unsigned AngleW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a_n, rst_b_n, start_a, start_b, abort_a, abort_b;
  logic [AngleW-1:0] angle_a, angle_b;
  logic              busy_a, busy_b, fd_a, fd_b;
  int                n_tests = 0;
  int                n_fail  = 0;

  nabp_map_sequencer_if #(.ACCU_W(AccuW), .ANGLE_W(AngleW)) if_a ();
  nabp_map_sequencer_if #(.ACCU_W(AccuW), .ANGLE_W(AngleW)) if_b ();

  nabp_map_sequencer #(
    .ACCU_W(AccuW), .ANGLE_W(AngleW), .NUM_ANGLES(3), .LINE_LEN(4)
  ) dut_a (
    .clk(clk), .reset_n(rst_a_n), .start_i(start_a), .abort_i(abort_a),
    .map_if(if_a.master), .angle_o(angle_a), .busy_o(busy_a), .frame_done_o(fd_a)
  );

  nabp_map_sequencer #(
    .ACCU_W(AccuW), .ANGLE_W(AngleW), .NUM_ANGLES(8), .LINE_LEN(8)
  ) dut_b (
    .clk(clk), .reset_n(rst_b_n), .start_i(start_b), .abort_i(abort_b),
    .map_if(if_b.master), .angle_o(angle_b), .busy_o(busy_b), .frame_done_o(fd_b)
  );

  // Registered ROM: init[a] = a*16, base[a] = a+1
  always @(posedge clk) begin
    if (if_a.rom_en) begin
      if_a.rom_init <= {12'd0, if_a.rom_addr, 4'd0};
      if_a.rom_base <= {16'd0, if_a.rom_addr} + 24'd1;
    end
    if (if_b.rom_en) begin
      if_b.rom_init <= {12'd0, if_b.rom_addr, 4'd0};
      if_b.rom_base <= {16'd0, if_b.rom_addr} + 24'd1;
    end
  end

  task automatic test_reset;
    logic any_b;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    if_a.lb_ready = 1'b1; if_a.stall = 1'b0;
    if_b.lb_ready = 1'b1; if_b.stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    any_b = if_b.rom_en | if_b.sh_kick | if_b.sh_shift_en | if_b.sh_done | fd_b | busy_b;
    n_tests++;
    if (any_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes_b: got %0b, want 0", any_b);
    end
    n_tests++;
    if (angle_b !== '0 || if_b.mp_accu_init !== '0 || if_b.mp_accu_base !== '0) begin
      n_fail++;
      $display("FAIL reset_regs_b: got angle=%0d init=%0d base=%0d, want 0/0/0",
               angle_b, if_b.mp_accu_init, if_b.mp_accu_base);
    end
    n_tests++;
    if (busy_a !== 1'b0 || angle_a !== '0 || if_a.rom_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_a: got busy=%0b angle=%0d, want 0/0", busy_a, angle_a);
    end
    @(posedge clk); #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
  endtask

  task automatic test_frame;
    int n_fetch = 0, n_kick = 0, n_done = 0, n_fd = 0, n_excl = 0;
    int fetch_i = -1, kick_i = -1, fd_i = -1;
    int addr_seen [3];
    int init_seen [3];
    int base_seen [3];
    int shifts    [3];
    for (int a = 0; a < 3; a++) begin
      addr_seen[a] = -1; init_seen[a] = -1; base_seen[a] = -1; shifts[a] = 0;
    end
    @(posedge clk); #1 start_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1 start_a = 1'b0;
      @(negedge clk);
      if (if_a.rom_en) begin
        if (n_fetch == 0) fetch_i = i;
        if (n_fetch < 3) addr_seen[n_fetch] = int'(if_a.rom_addr);
        n_fetch++;
      end
      if (if_a.sh_kick) begin
        if (n_kick == 0) kick_i = i;
        if (n_kick < 3) begin
          init_seen[n_kick] = int'(if_a.mp_accu_init);
          base_seen[n_kick] = int'(if_a.mp_accu_base);
        end
        n_kick++;
      end
      if (if_a.sh_shift_en && angle_a < 3) shifts[angle_a]++;
      if (if_a.sh_done) n_done++;
      if (fd_a) begin n_fd++; fd_i = i; end
      if (int'(if_a.sh_kick) + int'(if_a.sh_shift_en) + int'(if_a.sh_done) > 1) n_excl++;
    end
    n_tests++;
    if (fetch_i !== 0) begin n_fail++; $display("FAIL frame_fetch_lat: got %0d, want 0", fetch_i); end
    n_tests++;
    if (kick_i !== 2) begin n_fail++; $display("FAIL frame_kick_lat: got %0d, want 2", kick_i); end
    for (int a = 0; a < 3; a++) begin
      n_tests++;
      if (addr_seen[a] !== a || init_seen[a] !== a * 16 || base_seen[a] !== a + 1) begin
        n_fail++;
        $display("FAIL frame_params[%0d]: got addr=%0d init=%0d base=%0d, want %0d/%0d/%0d",
                 a, addr_seen[a], init_seen[a], base_seen[a], a, a * 16, a + 1);
      end
      n_tests++;
      if (shifts[a] !== 4) begin
        n_fail++; $display("FAIL frame_shifts[%0d]: got %0d, want 4", a, shifts[a]);
      end
    end
    n_tests++;
    if (n_fetch !== 3 || n_kick !== 3 || n_done !== 3) begin
      n_fail++;
      $display("FAIL frame_counts: got fetch=%0d kick=%0d done=%0d, want 3/3/3",
               n_fetch, n_kick, n_done);
    end
    // 24 cycles from the first FETCH through the last DONE inclusive
    n_tests++;
    if (n_fd !== 1 || fd_i !== 23) begin
      n_fail++; $display("FAIL frame_done: got count=%0d at=%0d, want 1 at 23", n_fd, fd_i);
    end
    n_tests++;
    if (n_excl !== 0) begin n_fail++; $display("FAIL strobe_excl: got %0d, want 0", n_excl); end
    n_tests++;
    if (busy_a !== 1'b0 || angle_a !== '0) begin
      n_fail++; $display("FAIL frame_idle: got busy=%0b angle=%0d, want 0/0", busy_a, angle_a);
    end
  endtask

  // Shift cycles are i=3..13; stalls at i=5,6 and i=12 (terminal count), plus KICK and DONE
  task automatic test_stall;
    int n_sh = 0, bad = 0;
    logic exp_sh;
    @(posedge clk); #1 start_b = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      if_b.stall = (i == 2 || i == 5 || i == 6 || i == 12 || i == 14);
      @(negedge clk);
      exp_sh = (i >= 3 && i <= 13 && i != 5 && i != 6 && i != 12);
      if (if_b.sh_shift_en !== exp_sh) bad++;
      if (if_b.sh_shift_en) n_sh++;
      if (if_b.sh_kick !== (i == 2)) bad++;
      if (if_b.sh_done !== (i == 14)) bad++;
    end
    n_tests++;
    if (n_sh !== 8) begin n_fail++; $display("FAIL stall_shift_count: got %0d, want 8", n_sh); end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_pattern: got %0d bad cycles, want 0", bad); end
  endtask

  task automatic test_lb_wait;
    int early_kick = 0, mp_bad = 0;
    logic fetch_ok = 1'b0, kick_ok = 1'b0;
    for (int j = 0; j < 14; j++) begin
      @(posedge clk); #1;
      if_b.stall    = 1'b0;
      if_b.lb_ready = (j >= 12);
      start_b       = (j == 5);
      @(negedge clk);
      if (j == 0) fetch_ok = if_b.rom_en && (if_b.rom_addr == 8'd1);
      if (j < 13 && if_b.sh_kick) early_kick++;
      if (j == 13) kick_ok = if_b.sh_kick;
      if (j >= 2 && (if_b.mp_accu_init !== 24'd16 || if_b.mp_accu_base !== 24'd2)) mp_bad++;
    end
    start_b = 1'b0;
    n_tests++;
    if (fetch_ok !== 1'b1) begin n_fail++; $display("FAIL lb_fetch_angle1: got 0, want 1"); end
    n_tests++;
    if (early_kick !== 0) begin n_fail++; $display("FAIL lb_early_kick: got %0d, want 0", early_kick); end
    n_tests++;
    if (kick_ok !== 1'b1) begin n_fail++; $display("FAIL lb_kick_after_ready: got %0b, want 1", kick_ok); end
    n_tests++;
    if (mp_bad !== 0) begin n_fail++; $display("FAIL lb_mp_stable: got %0d bad, want 0", mp_bad); end
  endtask

  task automatic test_abort;
    int n_sh = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if_b.lb_ready = 1'b1;
      start_b       = (k == 6);
      abort_b       = (k == 2 || k == 4);
      @(negedge clk);
      if (k < 2 && if_b.sh_shift_en) n_sh++;
      if (k == 2) begin
        n_tests++;
        if (n_sh !== 2) begin n_fail++; $display("FAIL abort_pre_shifts: got %0d, want 2", n_sh); end
        n_tests++;
        if (if_b.sh_done !== 1'b1 || if_b.sh_shift_en !== 1'b0 || fd_b !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_strobes: got done=%0b shift=%0b fd=%0b, want 1/0/0",
                   if_b.sh_done, if_b.sh_shift_en, fd_b);
        end
      end
      if (k == 3 || k == 5) begin
        n_tests++;
        if (busy_b !== 1'b0 || angle_b !== '0 || if_b.rom_en !== 1'b0 || if_b.sh_done !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_idle_k%0d: got busy=%0b angle=%0d, want 0/0", k, busy_b, angle_b);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (if_b.rom_en !== 1'b1 || if_b.rom_addr !== '0) begin
          n_fail++;
          $display("FAIL abort_restart: got rom_en=%0b addr=%0d, want 1/0",
                   if_b.rom_en, if_b.rom_addr);
        end
      end
    end
    abort_b = 1'b0; start_b = 1'b0;
  endtask

  task automatic test_reset_mid;
    int  per = 0;
    logic found = 1'b0, any;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (if_b.sh_kick) per = 0;
      if (if_b.sh_shift_en) per++;
      if (angle_b == 8'd5 && per == 3) found = 1'b1;
    end
    n_tests++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach: got 0, want 1"); end
    @(posedge clk); #1 rst_b_n = 1'b0;
    @(posedge clk); #1 rst_b_n = 1'b1;
    @(negedge clk);
    any = if_b.rom_en | if_b.sh_kick | if_b.sh_shift_en | if_b.sh_done | fd_b | busy_b;
    n_tests++;
    if (any !== 1'b0 || angle_b !== '0 || if_b.mp_accu_init !== '0 || if_b.mp_accu_base !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got strobes=%0b angle=%0d init=%0d, want 0/0/0",
               any, angle_b, if_b.mp_accu_init);
    end
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if_b.rom_en !== 1'b1 || if_b.rom_addr !== '0) begin
      n_fail++;
      $display("FAIL rstmid_restart: got rom_en=%0b addr=%0d, want 1/0", if_b.rom_en, if_b.rom_addr);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_lb_wait();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
